ir_multi_car_tx: RTL and testbench
==================================

# ir_multi_car_tx

Parametrised multi-car IR transmitter for the processor bus. One packet engine and one carrier generator serve `NUM_CARS` car profiles, each with its own burst lengths, gap and carrier period. Car select and command are held across packets and time out to neutral after `HOLD_PKTS` packets with no fresh bus write. The block sits on the bus at `BASE_ADDR` and drives the IR LED pin directly.

## Interface
- `BASE_ADDR`, 8'h90: bus write address.
- `NUM_CARS`, 4: number of car profiles (1..8). `IDX_W` = max(1, clog2(`NUM_CARS`)).
- `CLK_HZ`, 100_000_000: clock frequency.
- `PACKET_HZ`, 10: packet repeat rate. The interval `INTERVAL` = `CLK_HZ`/`PACKET_HZ` cycles.
- `HOLD_PKTS`, 5: packets sent with the written command before it reverts to 4'b0000. A value of 0 holds the command forever.
- `START_SZ`, `SEL_SZ`, `ASSERT_SZ`, `DEASSERT_SZ`, `GAP_SZ`: packed vectors of 8 bits per car, in carrier periods. Car i occupies bits [8i+7:8i].
  - Defaults for car0..3: start 191/88/88/192, select 47/22/44/24, assert 47/44/44/48, deassert 22/22/22/24, gap 25/40/40/24.
- `CARRIER_PER`: packed vector of 12 bits per car, in clock cycles. Defaults for car0..3: 2778/2500/2667/2778.
- `CLK` in 1: the single clock.
- `RESET` in 1: asynchronous, active-low reset.
- `BUS_WE` in 1: bus write strobe.
- `BUS_ADDR` in 8: bus address.
- `BUS_DATA` in 8: bus data. `[7:4]` is the car select one-hot, `[3:0]` is the command.
- `IR_LED` out 1: modulated IR output.
- `BUSY` out 1: high while a packet is in flight.
- `PKT_DONE` out 1: one-cycle pulse at the end of each packet.
- `ACTIVE_CAR` out `IDX_W`: car index of the current or most recent packet.

## Operation
**Bus write.** A write is `BUS_WE` high with `BUS_ADDR` == `BASE_ADDR`. On a write:
- `sel_reg` <= `BUS_DATA[NUM_CARS-1:0]` (taken from `[7:4]`; bits at or above `NUM_CARS` are ignored).
- `cmd_reg` <= `BUS_DATA[3:0]`.
- The hold counter is set to `HOLD_PKTS`.
- Writes to other addresses are ignored. `cmd_reg` is **not** cleared by bus idle.

**Car choice.** The lowest set bit of `sel_reg` is chosen. If `sel_reg` == 0, no packets are sent.

**Interval tick.** A free-running counter 0..`INTERVAL`-1 raises a tick at wrap.
- A tick with FSM in IDLE and a valid car starts a packet.
- A tick while `BUSY` is dropped; no queuing.

**Packet start snapshot.** At packet start the block latches:
- the car index into `ACTIVE_CAR`,
- that car's profile,
- `cmd_reg`.

Later writes affect only subsequent packets.

**Hold counter.** At each packet start, if `HOLD_PKTS` != 0 and the hold counter is nonzero, the counter decrements. When the counter reaches 0, `cmd_reg` <= 0. The car stays selected and neutral packets continue.

**FSM states:**
- IDLE -> START on a valid tick.
- START (start burst) -> GAP.
- GAP -> SEL after START, or -> CMD after SEL, or -> CMD for the next bit, or -> DONE after the bit-0 gap.
- SEL (select burst) -> GAP.
- CMD -> GAP. Command bits are sent MSB first (bit3 to bit0); a 1 bit uses an assert burst, a 0 bit uses a deassert burst.
- DONE -> IDLE, with `PKT_DONE` high for one cycle.

**Packet length.** Each packet is 6 bursts and 6 gaps: start, gap, select, gap, then 4 × (command burst, gap).

**Carrier.**
- During bursts, `IR_LED` is high for the first floor(P/2) cycles of each P-cycle period and low for the rest. The phase counter resets at each burst start.
- During gaps and IDLE, `IR_LED` is 0.
- A burst of N periods lasts exactly N·P cycles; a gap of G periods lasts G·P cycles.

**Counter widths.**
- The period counter is 12 bits.
- The burst/gap counter is 8 bits.
- The interval counter is clog2(`INTERVAL`) bits.
- No counter may wrap inside a phase.

## Timing
- **Reset values:** `IR_LED`=0, `BUSY`=0, `PKT_DONE`=0, `ACTIVE_CAR`=0, `sel_reg`=0, `cmd_reg`=0, hold counter=0, interval counter=0, FSM=IDLE.
- **Reset mid-packet:** all outputs go to 0 asynchronously; the packet is abandoned.
- **Bus write:** registered on the write edge and visible to the next tick.
- **Tick to carrier:** tick seen at edge t gives `BUSY`=1 and `IR_LED`=1 from t+1.
- **Packet length** (cycles) = (S + SEL + Σcmd bursts + 6·G)·P. `BUSY` is high for exactly this many cycles, then 1 DONE cycle.
- **Simultaneous events:**
  - Write and tick on the same edge: the tick uses the old registers.
  - Write to `sel_reg`=0 mid-packet: the current packet completes.

## Test plan
- **Car0, command 4'b1010.** Write 8'h1A at 8'h90 → after the next tick, the packet lasts (191+47+47+22+47+22+150)·2778 = 1,461,228 cycles. Check:
  - the start burst is 530,598 cycles of 1389-high/1389-low carrier;
  - `PKT_DONE` pulses once;
  - `ACTIVE_CAR`=0.
- **Car1, command 0.** Write 8'h20 → packet length 438·2500 = 1,095,000 cycles. All four command bursts are 22 periods.
- **Multi-select.** Write 8'hC5 → car2 is used (`ACTIVE_CAR`=2, P=2667) and the command is 0101.
- **Hold timeout**, bench with `HOLD_PKTS`=2, `INTERVAL` shortened, command F. Two packets carry 1111, then the 3rd onward carry 0000 with the same car.
- **Mid-packet write:** write a new command mid-packet → the current packet is unchanged and the next packet uses the new command. **Reset mid-packet:** `IR_LED` goes to 0 immediately.
- **Wrong address / no car.** A write at 8'h91 → no packets. Select 0 → no packets, `BUSY` stays 0.

Source files
------------

// File: rtl/ir_multi_car_tx.sv
// Multi-car IR transmitter: bus-written car select and command, sent as periodic
// start/select/4-bit-command burst packets on a per-car modulated carrier.
module ir_multi_car_tx #(
  parameter logic [7:0]            BASE_ADDR   = 8'h90,
  parameter int unsigned           NUM_CARS    = 4,
  parameter int unsigned           CLK_HZ      = 100_000_000,
  parameter int unsigned           PACKET_HZ   = 10,
  parameter int unsigned           HOLD_PKTS   = 5,
  parameter logic [8*NUM_CARS-1:0] START_SZ    = {8'd192, 8'd88, 8'd88, 8'd191},
  parameter logic [8*NUM_CARS-1:0] SEL_SZ      = {8'd24, 8'd44, 8'd22, 8'd47},
  parameter logic [8*NUM_CARS-1:0] ASSERT_SZ   = {8'd48, 8'd44, 8'd44, 8'd47},
  parameter logic [8*NUM_CARS-1:0] DEASSERT_SZ = {8'd24, 8'd22, 8'd22, 8'd22},
  parameter logic [8*NUM_CARS-1:0] GAP_SZ      = {8'd24, 8'd40, 8'd40, 8'd25},
  parameter logic [12*NUM_CARS-1:0] CARRIER_PER = {12'd2778, 12'd2667, 12'd2500, 12'd2778},
  localparam int unsigned          IDX_W       = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             BUS_WE,
  input  logic [7:0]       BUS_ADDR,
  input  logic [7:0]       BUS_DATA,
  output logic             IR_LED,
  output logic             BUSY,
  output logic             PKT_DONE,
  output logic [IDX_W-1:0] ACTIVE_CAR
);

  localparam int unsigned INTERVAL = CLK_HZ / PACKET_HZ;
  localparam int unsigned INT_W    = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [INT_W-1:0] INT_LAST = INT_W'(INTERVAL - 1);
  localparam int unsigned HOLD_W   = ($clog2(HOLD_PKTS + 1) > 0) ? $clog2(HOLD_PKTS + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_PKTS);

  typedef enum logic [2:0] {StIdle, StStart, StGap, StSel, StCmd, StDone} state_e;

  state_e              state_q, state_d;
  logic [INT_W-1:0]    int_cnt_q;
  logic [NUM_CARS-1:0] sel_q;
  logic [3:0]          cmd_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [IDX_W-1:0]    car_q;
  logic [3:0]          pkt_cmd_q;
  logic [2:0]          stage_q, stage_d;
  logic [11:0]         per_cnt_q, per_cnt_d;
  logic [7:0]          len_cnt_q, len_cnt_d;

  logic             bus_wr, tick, start_pkt, pick_valid, cmd_bit, in_burst;
  logic [IDX_W-1:0] pick_idx;
  logic [1:0]       bit_idx;
  logic [11:0]      cur_per;
  logic [7:0]       cur_len;

  assign bus_wr    = BUS_WE && (BUS_ADDR == BASE_ADDR);
  assign tick      = (int_cnt_q == INT_LAST);
  assign start_pkt = tick && (state_q == StIdle) && pick_valid;

  // Lowest set select bit wins
  always_comb begin
    pick_valid = |sel_q;
    pick_idx   = '0;
    for (int i = NUM_CARS - 1; i >= 0; i--) begin
      if (sel_q[i]) pick_idx = IDX_W'(i);
    end
  end

  // Profiles are elaboration constants, so latching the car index snapshots the profile
  assign cur_per = CARRIER_PER[12*int'(car_q) +: 12];
  assign bit_idx = 2'(3'd5 - stage_q);
  assign cmd_bit = pkt_cmd_q[bit_idx];

  always_comb begin
    cur_len = '0;
    case (state_q)
      StStart: cur_len = START_SZ[8*int'(car_q) +: 8];
      StSel:   cur_len = SEL_SZ[8*int'(car_q) +: 8];
      StCmd:   cur_len = cmd_bit ? ASSERT_SZ[8*int'(car_q) +: 8]
                                 : DEASSERT_SZ[8*int'(car_q) +: 8];
      StGap:   cur_len = GAP_SZ[8*int'(car_q) +: 8];
      default: cur_len = '0;
    endcase
  end

  // stage_q: 0 start, 1 select, 2..5 command bits 3..0
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    per_cnt_d = per_cnt_q;
    len_cnt_d = len_cnt_q;
    case (state_q)
      StIdle: begin
        if (start_pkt) begin
          state_d   = StStart;
          stage_d   = 3'd0;
          per_cnt_d = '0;
          len_cnt_d = '0;
        end
      end
      StStart, StSel, StCmd, StGap: begin
        if (per_cnt_q == cur_per - 12'd1) begin
          per_cnt_d = '0;
          len_cnt_d = len_cnt_q + 8'd1;
          if (len_cnt_q == cur_len - 8'd1) begin
            len_cnt_d = '0;
            if (state_q != StGap) begin
              state_d = StGap;
            end else if (stage_q == 3'd5) begin
              state_d = StDone;
            end else begin
              stage_d = stage_q + 3'd1;
              state_d = (stage_q == 3'd0) ? StSel : StCmd;
            end
          end
        end else begin
          per_cnt_d = per_cnt_q + 12'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= StIdle;
      stage_q   <= '0;
      per_cnt_q <= '0;
      len_cnt_q <= '0;
      int_cnt_q <= '0;
      car_q     <= '0;
      pkt_cmd_q <= '0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      per_cnt_q <= per_cnt_d;
      len_cnt_q <= len_cnt_d;
      int_cnt_q <= tick ? '0 : int_cnt_q + 1'b1;
      if (start_pkt) begin
        car_q     <= pick_idx;
        pkt_cmd_q <= cmd_q;
      end
    end
  end

  // A bus write on the same edge as a packet start overrides the hold decrement
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sel_q  <= '0;
      cmd_q  <= '0;
      hold_q <= '0;
    end else if (bus_wr) begin
      sel_q  <= NUM_CARS'(BUS_DATA[7:4]);
      cmd_q  <= BUS_DATA[3:0];
      hold_q <= HOLD_INIT;
    end else if (start_pkt && (HOLD_PKTS != 0) && (hold_q != '0)) begin
      hold_q <= hold_q - 1'b1;
      if (hold_q == HOLD_W'(1)) cmd_q <= '0;
    end
  end

  assign in_burst   = (state_q == StStart) || (state_q == StSel) || (state_q == StCmd);
  assign BUSY       = in_burst || (state_q == StGap);
  assign PKT_DONE   = (state_q == StDone);
  assign IR_LED     = in_burst && (per_cnt_q < {1'b0, cur_per[11:1]});
  assign ACTIVE_CAR = car_q;

endmodule

// File: tb/tb_ir_multi_car_tx.sv
// Directed bench for ir_multi_car_tx using short carrier periods and a 400-cycle interval.
module tb_ir_multi_car_tx;

  localparam int INTERVAL = 400;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       BUS_WE = 1'b0;
  logic [7:0] BUS_ADDR = 8'h00;
  logic [7:0] BUS_DATA = 8'h00;
  logic       IR_LED, BUSY, PKT_DONE;
  logic [1:0] ACTIVE_CAR;

  int vectors = 0;
  int miscompares = 0;

  // Packet capture results
  bit got;
  int busy_len, nb, first_hi, done_cnt, car_seen;
  int pulses[6];

  // car0: P=10, S4 SEL2 A3 D1 G2 | car1: P=8, 3 1 2 1 1 | car2: P=7, 5 2 2 1 1 | car3: P=6
  ir_multi_car_tx #(
    .BASE_ADDR  (8'h90),
    .NUM_CARS   (4),
    .CLK_HZ     (INTERVAL),
    .PACKET_HZ  (1),
    .HOLD_PKTS  (2),
    .START_SZ   ({8'd2, 8'd5, 8'd3, 8'd4}),
    .SEL_SZ     ({8'd2, 8'd2, 8'd1, 8'd2}),
    .ASSERT_SZ  ({8'd2, 8'd2, 8'd2, 8'd3}),
    .DEASSERT_SZ({8'd2, 8'd1, 8'd1, 8'd1}),
    .GAP_SZ     ({8'd2, 8'd1, 8'd1, 8'd2}),
    .CARRIER_PER({12'd6, 12'd7, 12'd8, 12'd10})
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BUS_WE    (BUS_WE),
    .BUS_ADDR  (BUS_ADDR),
    .BUS_DATA  (BUS_DATA),
    .IR_LED    (IR_LED),
    .BUSY      (BUSY),
    .PKT_DONE  (PKT_DONE),
    .ACTIVE_CAR(ACTIVE_CAR)
  );

  always #5 CLK = ~CLK;

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    @(negedge CLK);
    BUS_WE = 1'b1; BUS_ADDR = addr; BUS_DATA = data;
    @(negedge CLK);
    BUS_WE = 1'b0;
  endtask

  // Write while idle; a packet launched on the write edge itself used the old values, so skip it
  task automatic idle_write(input logic [7:0] addr, input logic [7:0] data);
    int t = 0;
    while (BUSY === 1'b1 && t < 1000) begin @(negedge CLK); t++; end
    bus_write(addr, data);
    t = 0;
    while (BUSY === 1'b1 && t < 1000) begin @(negedge CLK); t++; end
  endtask

  // Records one packet; bursts are split by low runs longer than one carrier period
  task automatic capture(input int per, input bit mid_en, input logic [7:0] mid_data);
    int t = 0;
    int low_run;
    logic prev;
    got = 0; busy_len = 0; nb = 0; first_hi = 0; done_cnt = 0; car_seen = -1;
    foreach (pulses[i]) pulses[i] = 0;
    while (BUSY !== 1'b1 && t < 3 * INTERVAL) begin @(negedge CLK); t++; end
    if (BUSY !== 1'b1) return;
    got = 1;
    car_seen = int'(ACTIVE_CAR);
    prev = 1'b0;
    low_run = per + 1;
    while (BUSY === 1'b1 && busy_len < 2000) begin
      if (IR_LED === 1'b1 && prev !== 1'b1) begin
        if (low_run > per) nb++;
        if (nb >= 1 && nb <= 6) pulses[nb-1]++;
      end
      if (IR_LED === 1'b1) low_run = 0; else low_run++;
      if (nb == 1 && pulses[0] == 1 && IR_LED === 1'b1) first_hi++;
      if (PKT_DONE === 1'b1) done_cnt++;
      prev = IR_LED;
      busy_len++;
      if (mid_en && busy_len == 50) begin
        BUS_WE = 1'b1; BUS_ADDR = 8'h90; BUS_DATA = mid_data;
      end
      @(negedge CLK);
      if (mid_en && busy_len == 50) BUS_WE = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      if (PKT_DONE === 1'b1) done_cnt++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    vectors++;
    if (IR_LED !== 1'b0) begin miscompares++; $display("FAIL reset_led: got %b want 0", IR_LED); end
    vectors++;
    if (BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    vectors++;
    if (PKT_DONE !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", PKT_DONE); end
    vectors++;
    if (ACTIVE_CAR !== 2'd0) begin
      miscompares++; $display("FAIL reset_car: got %0d want 0", ACTIVE_CAR);
    end
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_car0_cmd_a;
    int exp_p[6] = '{4, 2, 3, 1, 3, 1};
    idle_write(8'h90, 8'h1A);
    capture(10, 1'b0, 8'h00);
    vectors++;
    if (!got) begin miscompares++; $display("FAIL car0_got: no packet want 1"); end
    vectors++;
    if (busy_len != 260) begin miscompares++; $display("FAIL car0_len: got %0d want 260", busy_len); end
    vectors++;
    if (nb != 6) begin miscompares++; $display("FAIL car0_bursts: got %0d want 6", nb); end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (pulses[i] != exp_p[i]) begin
        miscompares++; $display("FAIL car0_burst%0d: got %0d want %0d", i, pulses[i], exp_p[i]);
      end
    end
    vectors++;
    if (first_hi != 5) begin miscompares++; $display("FAIL car0_duty: got %0d want 5", first_hi); end
    vectors++;
    if (done_cnt != 1) begin miscompares++; $display("FAIL car0_done: got %0d want 1", done_cnt); end
    vectors++;
    if (car_seen != 0) begin miscompares++; $display("FAIL car0_car: got %0d want 0", car_seen); end
  endtask

  task automatic test_car1_cmd_0;
    int exp_p[6] = '{3, 1, 1, 1, 1, 1};
    idle_write(8'h90, 8'h20);
    capture(8, 1'b0, 8'h00);
    vectors++;
    if (busy_len != 112) begin miscompares++; $display("FAIL car1_len: got %0d want 112", busy_len); end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (pulses[i] != exp_p[i]) begin
        miscompares++; $display("FAIL car1_burst%0d: got %0d want %0d", i, pulses[i], exp_p[i]);
      end
    end
    vectors++;
    if (first_hi != 4) begin miscompares++; $display("FAIL car1_duty: got %0d want 4", first_hi); end
    vectors++;
    if (car_seen != 1) begin miscompares++; $display("FAIL car1_car: got %0d want 1", car_seen); end
  endtask

  task automatic test_multi_select;
    int exp_p[6] = '{5, 2, 1, 2, 1, 2};
    idle_write(8'h90, 8'hC5);
    capture(7, 1'b0, 8'h00);
    vectors++;
    if (car_seen != 2) begin miscompares++; $display("FAIL multi_car: got %0d want 2", car_seen); end
    vectors++;
    if (busy_len != 133) begin miscompares++; $display("FAIL multi_len: got %0d want 133", busy_len); end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (pulses[i] != exp_p[i]) begin
        miscompares++; $display("FAIL multi_burst%0d: got %0d want %0d", i, pulses[i], exp_p[i]);
      end
    end
    vectors++;
    if (first_hi != 3) begin miscompares++; $display("FAIL multi_duty: got %0d want 3", first_hi); end
  endtask

  task automatic test_hold_timeout;
    int exp_len[4] = '{300, 300, 220, 220};
    int exp_b[4]   = '{3, 3, 1, 1};
    idle_write(8'h90, 8'h1F);
    for (int p = 0; p < 4; p++) begin
      capture(10, 1'b0, 8'h00);
      vectors++;
      if (busy_len != exp_len[p]) begin
        miscompares++; $display("FAIL hold_len%0d: got %0d want %0d", p, busy_len, exp_len[p]);
      end
      for (int i = 2; i < 6; i++) begin
        vectors++;
        if (pulses[i] != exp_b[p]) begin
          miscompares++;
          $display("FAIL hold_pkt%0d_bit%0d: got %0d want %0d", p, 5 - i, pulses[i], exp_b[p]);
        end
      end
      vectors++;
      if (car_seen != 0) begin miscompares++; $display("FAIL hold_car%0d: got %0d want 0", p, car_seen); end
    end
  endtask

  task automatic test_mid_packet_write;
    int exp_a[4] = '{3, 1, 3, 1};
    int exp_3[4] = '{1, 1, 3, 3};
    idle_write(8'h90, 8'h1A);
    capture(10, 1'b1, 8'h13);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (pulses[i+2] != exp_a[i]) begin
        miscompares++; $display("FAIL mid_cur_bit%0d: got %0d want %0d", 3 - i, pulses[i+2], exp_a[i]);
      end
    end
    capture(10, 1'b0, 8'h00);
    vectors++;
    if (busy_len != 260) begin miscompares++; $display("FAIL mid_next_len: got %0d want 260", busy_len); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (pulses[i+2] != exp_3[i]) begin
        miscompares++; $display("FAIL mid_next_bit%0d: got %0d want %0d", 3 - i, pulses[i+2], exp_3[i]);
      end
    end
  endtask

  task automatic test_no_packets;
    int busy_seen = 0;
    idle_write(8'h90, 8'h0F);
    repeat (2 * INTERVAL) begin @(negedge CLK); if (BUSY === 1'b1) busy_seen++; end
    vectors++;
    if (busy_seen != 0) begin miscompares++; $display("FAIL nocar_busy: got %0d want 0", busy_seen); end
    busy_seen = 0;
    bus_write(8'h91, 8'h1A);
    repeat (2 * INTERVAL) begin @(negedge CLK); if (BUSY === 1'b1) busy_seen++; end
    vectors++;
    if (busy_seen != 0) begin miscompares++; $display("FAIL wrongaddr_busy: got %0d want 0", busy_seen); end
  endtask

  task automatic test_reset_mid_packet;
    int t = 0;
    int busy_seen = 0;
    idle_write(8'h90, 8'h40);
    while (BUSY !== 1'b1 && t < 3 * INTERVAL) begin @(negedge CLK); t++; end
    repeat (2) @(negedge CLK);
    vectors++;
    if (IR_LED !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_led: got %b want 1", IR_LED); end
    vectors++;
    if (ACTIVE_CAR !== 2'd2) begin
      miscompares++; $display("FAIL rstmid_pre_car: got %0d want 2", ACTIVE_CAR);
    end
    #1 RESET = 1'b0;
    #1;
    vectors++;
    if (IR_LED !== 1'b0) begin miscompares++; $display("FAIL rstmid_led: got %b want 0", IR_LED); end
    vectors++;
    if (BUSY !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", BUSY); end
    vectors++;
    if (ACTIVE_CAR !== 2'd0) begin
      miscompares++; $display("FAIL rstmid_car: got %0d want 0", ACTIVE_CAR);
    end
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2 * INTERVAL) begin @(negedge CLK); if (BUSY === 1'b1) busy_seen++; end
    vectors++;
    if (busy_seen != 0) begin miscompares++; $display("FAIL rstmid_after: got %0d want 0", busy_seen); end
  endtask

  initial begin
    test_reset();
    test_car0_cmd_a();
    test_car1_cmd_0();
    test_multi_select();
    test_hold_timeout();
    test_mid_packet_write();
    test_no_packets();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
